// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory bus between instruction fetch
// and the data (MEM stage) requester. Data accesses win over fetches, each
// access is a request/acknowledge handshake with a bounded wait, and the
// pipeline is held via o_stallReq until every request of the current step
// has been served.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ifReq,
    input  logic [31:0] i_ifAddr,
    output logic [31:0] o_ifInst,
    input  logic        i_dReadEnable,
    input  logic        i_dWriteEnable,
    input  logic [31:0] i_dAddr,
    input  logic [3:0]  i_dSel,
    input  logic [31:0] i_dStoreData,
    output logic [31:0] o_dLoadData,
    output logic        o_stallReq,
    output logic        o_busError,
    output logic        o_memReq,
    output logic        o_memWrite,
    output logic [31:0] o_memAddr,
    output logic [3:0]  o_memSel,
    output logic [31:0] o_memWdata,
    input  logic        i_memAck,
    input  logic [31:0] i_memRdata
);

    typedef enum logic [1:0] {
        IDLE,
        IF_WAIT,
        D_WAIT
    } state_t;

    // Counter value seen in the last permitted wait cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic       if_served;
    logic       d_served;
    logic [7:0] wait_cnt;

    logic d_req;
    logic if_pend;
    logic d_pend;
    logic in_wait;
    logic timeout;
    logic done;

    // Pending/completion terms; stall stays up until the last pending access finishes.
    always_comb begin
        d_req      = i_dReadEnable | i_dWriteEnable;
        if_pend    = i_ifReq & ~if_served;
        d_pend     = d_req & ~d_served;
        in_wait    = (state == IF_WAIT) || (state == D_WAIT);
        timeout    = in_wait && !i_memAck && (wait_cnt == WAIT_LAST);
        done       = in_wait && (i_memAck || timeout);
        o_stallReq = (if_pend & ~((state == IF_WAIT) & done))
                   | (d_pend  & ~((state == D_WAIT)  & done));
    end

    // Bus sequencer: issue, wait for ack or timeout, capture, track served requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            o_memReq    <= 1'b0;
            o_memWrite  <= 1'b0;
            o_memAddr   <= 32'd0;
            o_memSel    <= 4'd0;
            o_memWdata  <= 32'd0;
            o_ifInst    <= 32'd0;
            o_dLoadData <= 32'd0;
            o_busError  <= 1'b0;
            if_served   <= 1'b0;
            d_served    <= 1'b0;
            wait_cnt    <= 8'd0;
        end else begin
            o_busError <= 1'b0;
            if (!o_stallReq) begin
                if_served <= 1'b0;
                d_served  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (d_pend) begin
                        o_memReq   <= 1'b1;
                        o_memWrite <= i_dWriteEnable;
                        o_memAddr  <= i_dAddr;
                        o_memSel   <= i_dSel;
                        o_memWdata <= i_dStoreData;
                        wait_cnt   <= 8'd0;
                        state      <= D_WAIT;
                    end else if (if_pend) begin
                        o_memReq   <= 1'b1;
                        o_memWrite <= 1'b0;
                        o_memAddr  <= i_ifAddr;
                        o_memSel   <= 4'b1111;
                        wait_cnt   <= 8'd0;
                        state      <= IF_WAIT;
                    end
                end
                IF_WAIT, D_WAIT: begin
                    if (done) begin
                        o_memReq   <= 1'b0;
                        o_busError <= timeout;
                        state      <= IDLE;
                        if (state == IF_WAIT) begin
                            o_ifInst <= i_memAck ? i_memRdata : 32'd0;
                            if (o_stallReq) begin
                                if_served <= 1'b1;
                            end
                        end else begin
                            if (!o_memWrite) begin
                                o_dLoadData <= i_memAck ? i_memRdata : 32'd0;
                            end
                            if (o_stallReq) begin
                                d_served <= 1'b1;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    o_memReq <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Each pipeline step queues
// the bus accesses it should cause (data first, then fetch) together with the
// memory latency to emulate; a responder plays the memory, and a monitor pops
// the queue whenever the arbiter starts an access and checks bus fields,
// captured data and error pulses.
module tb_mem_arbiter;

    localparam int TB_TIMEOUT = 4;

    typedef struct {
        logic        is_if;
        logic        write;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
    } acc_t;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_inst;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [3:0]  d_sel;
    logic [31:0] d_store;
    logic [31:0] d_load;
    logic        stall_req;
    logic        bus_error;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    acc_t exp_q[$];
    acc_t mem_q[$];

    int          n_checks;
    int          n_fail;
    int          resp_mode;
    logic        mon_en;
    logic        hung;
    logic [31:0] exp_if_inst;
    logic [31:0] exp_d_load;

    mem_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_ifReq        (if_req),
        .i_ifAddr       (if_addr),
        .o_ifInst       (if_inst),
        .i_dReadEnable  (d_read),
        .i_dWriteEnable (d_write),
        .i_dAddr        (d_addr),
        .i_dSel         (d_sel),
        .i_dStoreData   (d_store),
        .o_dLoadData    (d_load),
        .o_stallReq     (stall_req),
        .o_busError     (bus_error),
        .o_memReq       (mem_req),
        .o_memWrite     (mem_write),
        .o_memAddr      (mem_addr),
        .o_memSel       (mem_sel),
        .o_memWdata     (mem_wdata),
        .i_memAck       (mem_ack),
        .i_memRdata     (mem_rdata)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One pipeline step: queue the expected accesses, hold the inputs until
    // stall drops, and compare the number of stalled cycles with the sum of
    // (one idle cycle + effective wait cycles) per access, minus the final
    // completion cycle in which stall is already low.
    task automatic applyStimulus(input logic ifr, input logic [31:0] ia,
                                 input logic rd, input logic wr,
                                 input logic [31:0] da, input logic [3:0] sel,
                                 input logic [31:0] wd,
                                 input int lat_d, input int lat_i,
                                 input logic [31:0] rdat_d, input logic [31:0] rdat_i);
        acc_t a;
        int   exp_stall;
        int   cnt;
        exp_stall = 0;
        if (rd || wr) begin
            a = '{is_if: 1'b0, write: wr, addr: da, sel: sel, wdata: wd, lat: lat_d, rdata: rdat_d};
            exp_q.push_back(a);
            mem_q.push_back(a);
            exp_stall += 1 + ((lat_d < TB_TIMEOUT) ? lat_d : TB_TIMEOUT);
        end
        if (ifr) begin
            a = '{is_if: 1'b1, write: 1'b0, addr: ia, sel: 4'hF, wdata: 32'd0, lat: lat_i, rdata: rdat_i};
            exp_q.push_back(a);
            mem_q.push_back(a);
            exp_stall += 1 + ((lat_i < TB_TIMEOUT) ? lat_i : TB_TIMEOUT);
        end
        if (exp_stall > 0) exp_stall -= 1;
        if_req  = ifr;
        if_addr = ia;
        d_read  = rd;
        d_write = wr;
        d_addr  = da;
        d_sel   = sel;
        d_store = wd;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!stall_req) break;
            cnt++;
            if (cnt > exp_stall + 20) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL stall_timeout: stall still high after %0d cycles, expected %0d", cnt, exp_stall);
                hung = 1'b1;
                break;
            end
        end
        if (!hung) checkOutput("stall_cycles", 32'(cnt), 32'(exp_stall));
        @(posedge clk);
        #1;
    endtask

    // Memory model: quiet, random toggling, always-ack, or latency-driven
    // responses taken from the access queue (with stray acks while idle).
    initial begin
        acc_t cur_r;
        logic active;
        int   wc;
        active    = 1'b0;
        wc        = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            case (resp_mode)
                0: mem_ack = 1'b0;
                1: begin
                    mem_ack   = ($urandom_range(0, 1) == 1);
                    mem_rdata = $urandom;
                end
                2: begin
                    mem_ack   = 1'b1;
                    mem_rdata = 32'hCAFEF00D;
                end
                default: begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                    if (mem_req) begin
                        if (!active) begin
                            if (mem_q.size() != 0) begin
                                cur_r  = mem_q.pop_front();
                                active = 1'b1;
                                wc     = 1;
                            end
                        end else begin
                            wc++;
                        end
                        if (active) begin
                            if (wc == cur_r.lat) begin
                                mem_ack   = 1'b1;
                                mem_rdata = cur_r.rdata;
                                active    = 1'b0;
                            end else if (wc >= TB_TIMEOUT) begin
                                active = 1'b0;
                            end
                        end
                    end else begin
                        active  = 1'b0;
                        mem_ack = ($urandom_range(0, 3) == 0);
                    end
                end
            endcase
        end
    end

    // Monitor: pops the expected access at each new bus request, checks it
    // while held, and checks capture registers and error pulse afterwards.
    initial begin
        acc_t cur;
        logic in_acc;
        logic post_check;
        logic post_to;
        int   cnt;
        in_acc     = 1'b0;
        post_check = 1'b0;
        post_to    = 1'b0;
        cnt        = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (post_check) begin
                    checkOutput("if_inst", if_inst, exp_if_inst);
                    checkOutput("d_load", d_load, exp_d_load);
                    checkOutput("bus_error", 32'(bus_error), 32'(post_to));
                    checkOutput("idle_gap", 32'(mem_req), 32'd0);
                    post_check = 1'b0;
                end else if (mem_req && !in_acc) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_access: addr 0x%08h, expected no access", mem_addr);
                    end else begin
                        cur    = exp_q.pop_front();
                        in_acc = 1'b1;
                        cnt    = 1;
                        checkOutput("mem_write", 32'(mem_write), 32'(cur.write));
                        checkOutput("mem_addr", mem_addr, cur.addr);
                        checkOutput("mem_sel", 32'(mem_sel), 32'(cur.sel));
                        if (cur.write) checkOutput("mem_wdata", mem_wdata, cur.wdata);
                    end
                end else if (in_acc) begin
                    cnt++;
                    if (mem_req) begin
                        checkOutput("hold_addr", mem_addr, cur.addr);
                        checkOutput("hold_sel", 32'(mem_sel), 32'(cur.sel));
                        if (cur.write) checkOutput("hold_wdata", mem_wdata, cur.wdata);
                    end
                end
                if (in_acc) begin
                    if (!mem_req) begin
                        checkOutput("access_dropped", 32'(mem_req), 32'd1);
                        in_acc = 1'b0;
                    end else if (mem_ack || cnt == TB_TIMEOUT) begin
                        post_to = !mem_ack;
                        if (cur.is_if) exp_if_inst = mem_ack ? cur.rdata : 32'd0;
                        else if (!cur.write) exp_d_load = mem_ack ? cur.rdata : 32'd0;
                        post_check = 1'b1;
                        in_acc     = 1'b0;
                    end
                end
            end
        end
    end

    // Main sequence: reset checks, reset during an access, directed steps, random steps.
    initial begin
        logic        ifr;
        logic        rd;
        logic        wr;
        int          dk;
        n_checks    = 0;
        n_fail      = 0;
        hung        = 1'b0;
        mon_en      = 1'b0;
        exp_if_inst = 32'd0;
        exp_d_load  = 32'd0;
        resp_mode   = 1;
        rst         = 1'b1;
        if_req      = 1'b1;
        if_addr     = 32'h0000_0080;
        d_read      = 1'b1;
        d_write     = 1'b0;
        d_addr      = 32'h0000_0200;
        d_sel       = 4'hF;
        d_store     = 32'd0;

        repeat (4) begin
            @(negedge clk);
            checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
            checkOutput("rst_if_inst", if_inst, 32'd0);
            checkOutput("rst_d_load", d_load, 32'd0);
        end
        rst       = 1'b0;
        if_req    = 1'b0;
        d_read    = 1'b0;
        resp_mode = 0;
        @(negedge clk);
        checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_sel", 32'(mem_sel), 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_bus_error", 32'(bus_error), 32'd0);
        checkOutput("rst_stall", 32'(stall_req), 32'd0);

        $display("[TB] reset during a data wait");
        d_read = 1'b1;
        d_addr = 32'h0000_0300;
        @(negedge clk);
        checkOutput("mid_req_issued", 32'(mem_req), 32'd1);
        rst       = 1'b1;
        resp_mode = 2;
        @(negedge clk);
        checkOutput("mid_rst_req", 32'(mem_req), 32'd0);
        rst       = 1'b0;
        d_read    = 1'b0;
        resp_mode = 0;
        @(negedge clk);
        checkOutput("mid_late_ack_load", d_load, 32'd0);
        checkOutput("mid_late_ack_err", 32'(bus_error), 32'd0);
        checkOutput("mid_late_ack_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        checkOutput("mid_after_err", 32'(bus_error), 32'd0);

        resp_mode = 3;
        mon_en    = 1'b1;
        @(posedge clk);
        #1;
        $display("[TB] directed steps");
        applyStimulus(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0, 1, 3, 32'd0, 32'h2401_0005);
        applyStimulus(1'b1, 32'h0000_0044, 1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'd0, 1, 1, 32'h1111_2222, 32'h3333_4444);
        if (!hung) applyStimulus(1'b1, 32'h0000_0048, 1'b0, 1'b1, 32'h0000_0104, 4'b0011, 32'hDEAD_BEEF, 2, 2, 32'h5555_6666, 32'h7777_8888);
        if (!hung) applyStimulus(1'b1, 32'h0000_004C, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0, 1, 99, 32'd0, 32'h9999_AAAA);
        if (!hung) applyStimulus(1'b1, 32'h0000_0050, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0, 1, 1, 32'd0, 32'hBBBB_CCCC);
        if (!hung) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_0108, 4'hF, 32'd0, 5, 1, 32'hDDDD_EEEE, 32'd0);

        $display("[TB] random steps");
        for (int s = 0; s < 300 && !hung; s++) begin
            ifr = ($urandom_range(0, 3) != 0);
            dk  = int'($urandom_range(0, 3));
            rd  = (dk == 1) || (dk == 3);
            wr  = (dk == 2) || (dk == 3);
            applyStimulus(ifr, {$urandom_range(0, 1023), 2'b00}, rd, wr,
                          {$urandom_range(0, 4095), 2'b00}, 4'($urandom_range(1, 15)), $urandom,
                          int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), $urandom, $urandom);
        end

        if_req  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("exp_q_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("mem_q_drained", 32'(mem_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
